// File: rtl/freq_meter_if.sv
// Signal bundle between freq_meter and its user: measured input plus published result.
// The slave modport is the meter side; the master modport is the stimulus/readout side.
interface freq_meter_if #(
    parameter int COUNT_W = 26
);
    logic               sig_in;
    logic [COUNT_W-1:0] freq;
    logic               valid;
    logic               overflow;
    logic               gate_tick;

    modport master (
        output sig_in,
        input  freq,
        input  valid,
        input  overflow,
        input  gate_tick
    );

    modport slave (
        input  sig_in,
        output freq,
        output valid,
        output overflow,
        output gate_tick
    );
endinterface

// File: rtl/freq_meter.sv
// Frequency meter: counts rising edges of sig_in over a fixed gate window of clk_50MHz cycles.
// Optional glitch filter enabled by defining FREQ_METER_GLITCH_FILTER_EN.
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int COUNT_W     = 26
) (
    input  logic         clk_50MHz,
    input  logic         set,
    freq_meter_if.slave  bus
);

    localparam int            GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic {
        RUN,
        CLOSE
    } state_e;

    state_e               state_q, state_d;
    logic [GATE_W-1:0]    gate_q, gate_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;
    logic                 sat_q, sat_d;
    logic [COUNT_W-1:0]   freq_q, freq_d;
    logic                 ovf_q, ovf_d;
    logic                 valid_q, valid_d;

    logic s1_q, s2_q, prev_q;
    logic level;
    logic edge_det;
    logic cnt_full;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50MHz or posedge set) begin
        if (set) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= bus.sig_in;
            s2_q <= s1_q;
        end
    end

`ifdef FREQ_METER_GLITCH_FILTER_EN
    // Majority of the last two samples and the previous decision: a level must be seen on
    // two consecutive samples before the output follows it, so 1-cycle pulses never pass.
    logic hist_q, filt_q;

    always_ff @(posedge clk_50MHz or posedge set) begin
        if (set) begin
            hist_q <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= s2_q;
            filt_q <= (s2_q & hist_q) | (s2_q & filt_q) | (hist_q & filt_q);
        end
    end

    assign level = filt_q;
`else
    assign level = s2_q;
`endif

    always_ff @(posedge clk_50MHz or posedge set) begin
        if (set) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign edge_det = level & ~prev_q;
    assign cnt_full = &cnt_q;

    always_ff @(posedge clk_50MHz or posedge set) begin
        if (set) begin
            state_q <= RUN;
            gate_q  <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        gate_d  = gate_q + 1'b1;
        state_d = RUN;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        freq_d  = freq_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;

        if (state_q == CLOSE) begin
            gate_d = '0;
        end
        // CLOSE is registered so it lines up exactly with the terminal gate count.
        if (gate_d == GATE_LAST) begin
            state_d = CLOSE;
        end

        unique case (state_q)
            RUN: begin
                if (edge_det) begin
                    if (cnt_full) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CLOSE: begin
                // An edge detected in the terminal cycle still belongs to the closing window.
                freq_d  = (edge_det && !cnt_full) ? cnt_q + 1'b1 : cnt_q;
                ovf_d   = sat_q | (edge_det & cnt_full);
                valid_d = 1'b1;
                cnt_d   = '0;
                sat_d   = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.freq      = freq_q;
    assign bus.overflow  = ovf_q;
    assign bus.valid     = valid_q;
    assign bus.gate_tick = (state_q == CLOSE);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: reset timing, steady rate, saturation, mid-window reset, glitches.
// Two instances share clock and reset: a 12-bit counter and a 6-bit one for saturation.
module tb_freq_meter;

    localparam int GATE = 1000;
    localparam int W_A  = 12;
    localparam int W_B  = 6;

`ifdef FREQ_METER_GLITCH_FILTER_EN
    localparam int GLITCH_FREQ = 0;
`else
    localparam int GLITCH_FREQ = 50;
`endif

    logic clk_50MHz = 1'b0;
    logic set       = 1'b1;

    freq_meter_if #(.COUNT_W(W_A)) if_a ();
    freq_meter_if #(.COUNT_W(W_B)) if_b ();

    freq_meter #(.GATE_CYCLES(GATE), .COUNT_W(W_A)) dut_a (
        .clk_50MHz (clk_50MHz),
        .set       (set),
        .bus       (if_a)
    );

    freq_meter #(.GATE_CYCLES(GATE), .COUNT_W(W_B)) dut_b (
        .clk_50MHz (clk_50MHz),
        .set       (set),
        .bus       (if_b)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        total++;
        if (got !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stimulus modes: 0 idle low, 1 period-10 square, 2 one-cycle pulse every 20, 3 period-4 square.
    int mode_a = 0;
    int mode_b = 0;
    int ph     = 0;

    function automatic logic gen(input int mode, input int p);
        case (mode)
            1:       return (p % 10) < 5;
            2:       return (p % 20) == 0;
            3:       return (p % 4) < 2;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        if_a.sig_in = 1'b0;
        if_b.sig_in = 1'b0;
        forever begin
            @(posedge clk_50MHz);
            #2;
            ph++;
            if_a.sig_in = gen(mode_a, ph);
            if_b.sig_in = gen(mode_b, ph);
        end
    end

    task automatic wait_valid(input bit sel, output int cycles);
        cycles = 0;
        forever begin
            @(negedge clk_50MHz);
            cycles++;
            if ((sel ? if_b.valid : if_a.valid) === 1'b1) return;
            if (cycles >= 2000) begin
                check(sel ? "timeout_b" : "timeout_a", 32'd0, 1);
                return;
            end
        end
    endtask

    initial begin
        int c;
        int tick1, tick2, val1, val2, nval;

        // Reset: outputs held at zero, then first tick/valid at 999/1000 after release.
        set = 1'b1;
        repeat (5) @(negedge clk_50MHz);
        check("rst_freq",  32'(if_a.freq), 0);
        check("rst_valid", 32'(if_a.valid), 0);
        check("rst_ovf",   32'(if_a.overflow), 0);
        check("rst_tick",  32'(if_a.gate_tick), 0);
        set = 1'b0;

        tick1 = -1; tick2 = -1; val1 = -1; val2 = -1; nval = 0;
        for (int n = 1; n <= 2100; n++) begin
            @(negedge clk_50MHz);
            if (if_a.gate_tick === 1'b1) begin
                if (tick1 < 0) tick1 = n;
                else if (tick2 < 0) tick2 = n;
            end
            if (if_a.valid === 1'b1) begin
                nval++;
                if (val1 < 0) begin
                    val1 = n;
                    check("first_freq", 32'(if_a.freq), 0);
                    check("first_ovf",  32'(if_a.overflow), 0);
                end else if (val2 < 0) begin
                    val2 = n;
                end
            end
        end
        check("tick1_cycle",  32'(tick1), 999);
        check("valid1_cycle", 32'(val1), 1000);
        check("tick2_cycle",  32'(tick2), 1999);
        check("valid2_cycle", 32'(val2), 2000);
        check("valid_count",  32'(nval), 2);

        // Steady period-10 input: 100 edges per window.
        mode_a = 1;
        wait_valid(1'b0, c);
        for (int k = 0; k < 2; k++) begin
            wait_valid(1'b0, c);
            check("steady_freq",   32'(if_a.freq), 100);
            check("steady_ovf",    32'(if_a.overflow), 0);
            check("steady_period", 32'(c), 1000);
        end

        // Reset at mid-window: immediate clear, full window after release.
        repeat (500) @(negedge clk_50MHz);
        set = 1'b1;
        #1;
        check("mid_freq_clr",  32'(if_a.freq), 0);
        check("mid_valid_clr", 32'(if_a.valid), 0);
        repeat (3) @(negedge clk_50MHz);
        for (int i = 0; i < 20 && if_a.sig_in !== 1'b0; i++) @(negedge clk_50MHz);
        set = 1'b0;
        wait_valid(1'b0, c);
        check("mid_period", 32'(c), 1000);
        check("mid_freq",   32'(if_a.freq), 100);
        check("mid_ovf",    32'(if_a.overflow), 0);

        // Saturation on the 6-bit instance: 250 edges clamp to 63 with overflow.
        mode_b = 3;
        wait_valid(1'b1, c);
        for (int k = 0; k < 2; k++) begin
            wait_valid(1'b1, c);
            check("sat_freq", 32'(if_b.freq), 63);
            check("sat_ovf",  32'(if_b.overflow), 1);
        end
        mode_b = 0;
        wait_valid(1'b1, c);
        wait_valid(1'b1, c);
        check("stop_freq", 32'(if_b.freq), 0);
        check("stop_ovf",  32'(if_b.overflow), 0);

        // Single-cycle pulses every 20 cycles, then back to a clean square wave.
        mode_a = 2;
        wait_valid(1'b0, c);
        wait_valid(1'b0, c);
        check("glitch_freq", 32'(if_a.freq), GLITCH_FREQ);
        mode_a = 1;
        wait_valid(1'b0, c);
        wait_valid(1'b0, c);
        check("square_freq", 32'(if_a.freq), 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Reciprocal of the clock divider: it measures the frequency of an external digital signal against the 50 MHz system clock. A gate counter opens a fixed window of `GATE_CYCLES` system clocks (1 s by default). Rising edges of the synchronised input are counted during each window and the count is published with a one-cycle `valid` strobe. The block sits beside the divider in the top level and feeds the display/readout logic with Hz values.

## Interface
- `GATE_CYCLES`, default 50_000_000: window length in `clk_50MHz` cycles; must be ≥ 8.
- `COUNT_W`, default 26: width of the edge counter and the `freq` result.
- `clk_50MHz`  in  1: system clock, rising-edge active.
- `set`  in  1: reset, asynchronous, active-high. It clears all state immediately.
- `sig_in`  in  1: measured signal, asynchronous to `clk_50MHz`; must be < 25 MHz.
- `freq`  out  COUNT_W: edge count of the last completed window. Reset value 0.
- `valid`  out  1: one-cycle strobe when `freq` updates. Reset value 0.
- `overflow`  out  1: the last completed window saturated the counter. Reset value 0.
- `gate_tick`  out  1: one-cycle pulse on the final cycle of each window. Reset value 0.

## Operation
- **Input synchroniser:** two flops, `s1` then `s2`, both reset to 0.
- **Edge detector:** register `prev` holds the previous `s2` value and resets to 0. A rising edge is `s2 & ~prev`. Consequence: if `sig_in` is high when `set` is released, that counts as one edge.
- **Gate counter:**
  - Width is ceil(log2(GATE_CYCLES)).
  - Counts 0 to GATE_CYCLES-1 and wraps to 0.
  - Resets to 0.
  - `gate_tick` is asserted while the counter equals GATE_CYCLES-1.
- **Edge counter:**
  - Width is COUNT_W.
  - Increments on each detected edge and saturates at 2^COUNT_W-1.
  - A sticky `sat` flag is set if an increment is attempted while the counter is at all-ones.
- **Window close (cycle where gate counter = GATE_CYCLES-1):**
  - `freq` is loaded with the edge count including any edge detected in this same cycle, saturated.
  - `overflow` is loaded with `sat`, or with a saturating edge in this cycle.
  - `valid` is set for the next cycle only.
  - The edge counter and `sat` restart at 0.
- **Between windows:** `freq` and `overflow` hold their values.
- **No other control states:** the block free-runs. The FSM is trivial: RUN, with a CLOSE action on the terminal count.
- **`set` mid-window:** the partial count is discarded and all outputs go to 0 asynchronously. The first window after release runs a full GATE_CYCLES.

## Timing
- `sig_in` rising to edge detection takes 3 `clk_50MHz` edges: `s1`, `s2`, then the compare against `prev`.
- An edge reaching the detector in the terminal cycle belongs to the closing window. Later edges belong to the next window, with no double count and no loss.
- `freq`, `overflow` and `valid` are registered and update on the clock edge after the terminal cycle.
- `valid` pulses exactly once every GATE_CYCLES cycles. The first pulse comes GATE_CYCLES cycles after `set` is released.
- `gate_tick` leads `valid` by exactly 1 cycle.

## Configuration
- **`FREQ_METER_GLITCH_FILTER_EN` defined:**
  - A 3-sample majority filter sits between `s2` and the edge detector. It uses two extra flops, reset to 0.
  - A level must persist for ≥ 2 consecutive samples to pass, so isolated 1-cycle pulses are rejected.
  - Detection latency becomes 5 cycles.
  - The maximum measurable frequency becomes < 12.5 MHz.
- **Not defined:** no filter, 3-cycle latency, and every sampled rising edge counts.

## Test plan
All scenarios use `GATE_CYCLES`=1000 and `COUNT_W`=12 unless stated.
- **Reset:** hold `set`=1 for 5 cycles with `sig_in`=0, then release.
  - All outputs are 0 during reset.
  - `gate_tick` pulses at cycle 999 after release and `valid` at cycle 1000, with `freq`=0 and `overflow`=0.
  - The pulses repeat every 1000 cycles.
- **Steady frequency:** `sig_in` toggles every 5 cycles (period 10) from before the first window. Every `valid` reports `freq`=100 and `overflow`=0.
- **Saturation:** `COUNT_W`=6, `sig_in` with period 4 cycles.
  - Each window reports `freq`=63 and `overflow`=1.
  - When the input stops, the next window reports `freq`=0 and `overflow`=0.
- **Reset mid-window:** with the period-10 input running, pulse `set` at cycle 500 of a window.
  - Outputs drop to 0 in the same cycle.
  - The next `valid` arrives 1000 cycles after release with `freq`=100.
- **Glitch filter:** single-cycle high pulses every 20 cycles.
  - With `FREQ_METER_GLITCH_FILTER_EN` defined: `freq`=0.
  - Without it: `freq`=50.
  - A period-10 square wave reports 100 in both builds.
